cska16_arb: RTL



---
 rtl/cska16_arb.sv | 100 ++++++++++
 1 files changed

// File: rtl/cska16_arb.sv
`default_nettype none
// ==========================================================================
// cska16_arb : two-port round-robin arbiter/sequencer for a shared cska16
// Revision   : 1.0
// ==========================================================================
module cska16_arb #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req_cin,
  input  logic [1:0]       req_use_carry,
  input  logic [1:0]       req_lock,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout
);

  logic       last;
  logic       locked;
  logic       owner;
  logic [1:0] carry;
  logic [1:0] grant;
  logic       accept;
  logic       gsel;

  // A held lock starves the other requester even while the owner is idle.
  always_comb begin
    grant = 2'b00;
    if (locked) begin
      grant[owner] = req_valid[owner];
    end else begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;
  assign accept    = |grant;
  assign gsel      = grant[1];

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (grant[0]) begin
      add_a   = req0_a;
      add_b   = req0_b;
      add_cin = req_use_carry[0] ? carry[0] : req_cin[0];
    end else if (grant[1]) begin
      add_a   = req1_a;
      add_b   = req1_b;
      add_cin = req_use_carry[1] ? carry[1] : req_cin[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      carry     <= 2'b00;
      locked    <= 1'b0;
      owner     <= 1'b0;
      last      <= 1'b1;
    end else if (accept) begin
      rsp_valid    <= 1'b1;
      rsp_id       <= gsel;
      rsp_sum      <= add_sum;
      rsp_cout     <= add_cout;
      carry[gsel]  <= add_cout;
      last         <= gsel;
      locked       <= req_lock[gsel];
      if (req_lock[gsel]) begin
        owner <= gsel;
      end
    end else begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
